// File: rtl/vortex_mem_ahb_sequencer_if.sv
// Signal bundle between the Vortex memory port, the line sequencer and the word-wide bus manager.
// The master modport is the sequencer's view; the slave modport is the surrounding environment's view.
interface vortex_mem_ahb_sequencer_if #(
   parameter int LINE_BITS      = 512,
   parameter int WORD_BITS      = 32,
   parameter int LINE_ADDR_BITS = 26,
   parameter int TAG_BITS       = 56,
   parameter int BUS_ADDR_BITS  = 32
);
   logic                      mem_req_valid;
   logic                      mem_req_rw;
   logic [LINE_BITS/8-1:0]    mem_req_byteen;
   logic [LINE_ADDR_BITS-1:0] mem_req_addr;
   logic [LINE_BITS-1:0]      mem_req_data;
   logic [TAG_BITS-1:0]       mem_req_tag;
   logic                      mem_req_ready;
   logic                      mem_rsp_valid;
   logic [LINE_BITS-1:0]      mem_rsp_data;
   logic [TAG_BITS-1:0]       mem_rsp_tag;
   logic                      mem_rsp_ready;
   logic                      bus_ren;
   logic                      bus_wen;
   logic [BUS_ADDR_BITS-1:0]  bus_addr;
   logic [WORD_BITS-1:0]      bus_wdata;
   logic [WORD_BITS/8-1:0]    bus_strobe;
   logic [WORD_BITS-1:0]      bus_rdata;
   logic                      bus_request_stall;
   logic                      bus_error;

   modport master (
      input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      input  mem_rsp_ready,
      output bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe,
      input  bus_rdata, bus_request_stall, bus_error
   );

   modport slave (
      output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      output mem_rsp_ready,
      input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe,
      output bus_rdata, bus_request_stall, bus_error
   );
endinterface

// File: rtl/vortex_mem_ahb_sequencer.sv
// Breaks one Vortex cache-line request into word beats on the bus manager port and, for reads,
// reassembles the returned words into a tagged line response. One request in flight at a time.
module vortex_mem_ahb_sequencer #(
   parameter int                 LINE_BITS      = 512,
   parameter int                 WORD_BITS      = 32,
   parameter int                 LINE_ADDR_BITS = 26,
   parameter int                 TAG_BITS       = 56,
   parameter int                 BUS_ADDR_BITS  = 32,
   parameter logic [BUS_ADDR_BITS-1:0] BASE_ADDR = '0
) (
   input  logic                           clk,
   input  logic                           nRST,
   vortex_mem_ahb_sequencer_if.master     io,
   output logic                           busy,
   output logic                           err_sticky,
   input  logic                           err_clear
);
   localparam int BEATS    = LINE_BITS / WORD_BITS;
   localparam int SW       = WORD_BITS / 8;
   localparam int BEAT_W   = $clog2(BEATS);
   localparam int LINE_OFS = $clog2(LINE_BITS / 8);
   localparam int WORD_OFS = $clog2(SW);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                    state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [LINE_BITS/8-1:0]    byteen_q, byteen_d;
   logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
   logic [LINE_BITS-1:0]      data_q, data_d;
   logic [TAG_BITS-1:0]       tag_q, tag_d;
   logic [LINE_BITS-1:0]      line_q, line_d;
   logic                      err_q, err_d;

   logic [SW-1:0]             slice;
   logic [BUS_ADDR_BITS-1:0]  beat_addr;
   logic                      done;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         byteen_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         tag_q    <= '0;
         line_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         byteen_q <= byteen_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         tag_q    <= tag_d;
         line_q   <= line_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      slice     = byteen_q[int'(beat_q)*SW +: SW];
      beat_addr = BASE_ADDR
                + BUS_ADDR_BITS'({addr_q, {LINE_OFS{1'b0}}})
                + BUS_ADDR_BITS'({beat_q, {WORD_OFS{1'b0}}});

      state_d  = state_q;
      beat_d   = beat_q;
      byteen_d = byteen_q;
      addr_d   = addr_q;
      data_d   = data_q;
      tag_d    = tag_q;
      line_d   = line_q;
      err_d    = err_q;
      done     = 1'b0;

      io.mem_req_ready = 1'b0;
      io.mem_rsp_valid = 1'b0;
      io.mem_rsp_data  = '0;
      io.mem_rsp_tag   = '0;
      io.bus_ren       = 1'b0;
      io.bus_wen       = 1'b0;
      io.bus_addr      = '0;
      io.bus_wdata     = '0;
      io.bus_strobe    = '0;

      unique case (state_q)
         IDLE: begin
            io.mem_req_ready = 1'b1;
            if (io.mem_req_valid) begin
               byteen_d = io.mem_req_byteen;
               addr_d   = io.mem_req_addr;
               data_d   = io.mem_req_data;
               tag_d    = io.mem_req_tag;
               beat_d   = '0;
               state_d  = io.mem_req_rw ? WRITE : READ;
            end
         end
         READ: begin
            io.bus_ren    = 1'b1;
            io.bus_addr   = beat_addr;
            io.bus_strobe = '1;
            done          = !io.bus_request_stall;
            if (done) begin
               line_d[int'(beat_q)*WORD_BITS +: WORD_BITS] = io.bus_rdata;
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = RESP;
            end
         end
         WRITE: begin
            io.bus_wen    = |slice;
            io.bus_addr   = beat_addr;
            io.bus_wdata  = data_q[int'(beat_q)*WORD_BITS +: WORD_BITS];
            io.bus_strobe = slice;
            done          = io.bus_wen && !io.bus_request_stall;
            // A beat with no enabled bytes is skipped without touching the bus.
            if (done || !io.bus_wen) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = IDLE;
            end
         end
         RESP: begin
            io.mem_rsp_valid = 1'b1;
            io.mem_rsp_data  = line_q;
            io.mem_rsp_tag   = tag_q;
            if (io.mem_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A fresh error outranks a same-cycle clear.
      if (done && io.bus_error) err_d = 1'b1;
      else if (err_clear)       err_d = 1'b0;
   end

   assign busy       = (state_q != IDLE);
   assign err_sticky = err_q;

endmodule

// File: tb/tb_vortex_mem_ahb_sequencer.sv
// Bench for vortex_mem_ahb_sequencer: a table of line transactions plus hand-written stall, error,
// response back-pressure and mid-transaction reset sequences, checked through beat/response queues.
module tb_vortex_mem_ahb_sequencer;
   logic clk = 1'b0;
   logic nRST;
   logic busy, err_sticky, err_clear;

   vortex_mem_ahb_sequencer_if io ();

   vortex_mem_ahb_sequencer dut (
      .clk        (clk),
      .nRST       (nRST),
      .io         (io),
      .busy       (busy),
      .err_sticky (err_sticky),
      .err_clear  (err_clear)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strobe;
   } beat_t;

   typedef struct packed {
      logic [511:0] data;
      logic [55:0]  tag;
   } rsp_t;

   typedef struct {
      bit           rw;
      logic [25:0]  addr;
      logic [63:0]  be;
      logic [31:0]  seed;
      logic [55:0]  tag;
      int           lat;
   } vec_t;

   beat_t exp_beats[$];
   rsp_t  exp_rsp[$];
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string name, input logic [575:0] act, input logic [575:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [511:0] exp_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      return l;
   endfunction

   // One clock: bus model and monitor at the falling edge, then return just after the rising edge.
   task automatic cyc();
      beat_t a, e;
      rsp_t  ra, re;
      @(negedge clk);
      io.bus_rdata = 32'hA000_0000 + ((io.bus_addr >> 2) & 32'hF);
      if ((io.bus_ren || io.bus_wen) && !io.bus_request_stall) begin
         a.ren    = io.bus_ren;
         a.wen    = io.bus_wen;
         a.addr   = io.bus_addr;
         a.wdata  = io.bus_wen ? io.bus_wdata : 32'h0;
         a.strobe = io.bus_strobe;
         if (exp_beats.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %0h expected none", a);
         end else begin
            e = exp_beats.pop_front();
            check("beat", 576'(a), 576'(e));
         end
      end
      if (io.mem_rsp_valid && io.mem_rsp_ready) begin
         ra.data = io.mem_rsp_data;
         ra.tag  = io.mem_rsp_tag;
         if (exp_rsp.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got tag %0h expected none", ra.tag);
         end else begin
            re = exp_rsp.pop_front();
            check("rsp", 576'(ra), 576'(re));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_txn(input bit rw, input logic [25:0] addr, input logic [63:0] be,
                           input logic [31:0] seed, input logic [55:0] tag);
      beat_t b;
      rsp_t  r;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) begin
         a = {addr, 6'b0} + 32'(4 * i);
         if (!rw) begin
            b = '{ren: 1'b1, wen: 1'b0, addr: a, wdata: 32'h0, strobe: 4'hF};
            exp_beats.push_back(b);
         end else if (be[i*4 +: 4] != 4'h0) begin
            b = '{ren: 1'b0, wen: 1'b1, addr: a, wdata: seed + 32'(i), strobe: be[i*4 +: 4]};
            exp_beats.push_back(b);
         end
      end
      if (!rw) begin
         r.data = exp_line();
         r.tag  = tag;
         exp_rsp.push_back(r);
      end
   endtask

   // Presents a request for exactly one cycle (the accept cycle, cycle 0).
   task automatic start(input bit rw, input logic [25:0] addr, input logic [63:0] be,
                        input logic [31:0] seed, input logic [55:0] tag);
      io.mem_req_valid  = 1'b1;
      io.mem_req_rw     = rw;
      io.mem_req_addr   = addr;
      io.mem_req_byteen = be;
      io.mem_req_tag    = tag;
      for (int i = 0; i < 16; i++) io.mem_req_data[i*32 +: 32] = rw ? seed + 32'(i) : 32'h0;
      check("req_ready_idle", 576'(io.mem_req_ready), 576'(1));
      push_txn(rw, addr, be, seed, tag);
      cyc();
      io.mem_req_valid = 1'b0;
   endtask

   vec_t vt[6];

   initial begin
      int t;
      int rsp_seen;
      vt[0] = '{1'b0, 26'h1,       64'h0,                  32'h0,         56'h12_3456_789A_BCDE, 17};
      vt[1] = '{1'b1, 26'h2,       64'hFFFF_FFFF_FFFF_FFFF, 32'h0,        56'h0,                 17};
      vt[2] = '{1'b1, 26'h3,       64'hF000_0000_0000_00F0, 32'h100,      56'h0,                 17};
      vt[3] = '{1'b1, 26'h4,       64'h0,                  32'h200,       56'h0,                 17};
      vt[4] = '{1'b1, 26'h3FF_FFFF, 64'h0123_4567_89AB_CDEF, 32'hCAFE_0000, 56'h0,               17};
      vt[5] = '{1'b0, 26'h2A5,     64'h0,                  32'h0,         56'hFF_0000_0000_0001, 17};

      io.mem_req_valid     = 1'b0;
      io.mem_req_rw        = 1'b0;
      io.mem_req_byteen    = '0;
      io.mem_req_addr      = '0;
      io.mem_req_data      = '0;
      io.mem_req_tag       = '0;
      io.mem_rsp_ready     = 1'b1;
      io.bus_rdata         = '0;
      io.bus_request_stall = 1'b0;
      io.bus_error         = 1'b0;
      err_clear            = 1'b0;
      nRST                 = 1'b1;
      #2 nRST = 1'b0;
      #20;
      check("reset_outputs",
            576'({io.mem_req_ready, busy, io.bus_ren, io.bus_wen, io.mem_rsp_valid, err_sticky,
                  io.bus_addr, io.bus_wdata, io.bus_strobe, io.mem_rsp_tag, io.mem_rsp_data}),
            576'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 56'h0, 512'h0}));
      @(posedge clk);
      #1 nRST = 1'b1;

      // Table of transactions with no stalls.
      for (int v = 0; v < 6; v++) begin
         start(vt[v].rw, vt[v].addr, vt[v].be, vt[v].seed, vt[v].tag);
         t = 1;
         while (t < 60) begin
            if (!vt[v].rw && io.mem_rsp_valid) break;
            if (vt[v].rw && io.mem_req_ready) break;
            check("ready_low_busy", 576'({io.mem_req_ready, busy}), 576'(2'b01));
            cyc();
            t++;
         end
         check("latency", 576'(t), 576'(vt[v].lat));
         if (!vt[v].rw) cyc();
         check("idle_after", 576'({io.mem_req_ready, busy, io.mem_rsp_valid}), 576'(3'b100));
         check("queues_drained", 576'(exp_beats.size() + exp_rsp.size()), 576'(0));
      end

      // Stall beat 5 for three cycles.
      start(1'b0, 26'h5, 64'h0, 32'h0, 56'h55);
      t = 1;
      while (t < 40) begin
         io.bus_request_stall = (t >= 6 && t <= 8);
         if (t >= 6 && t <= 8)
            check("stall_hold", 576'({io.bus_ren, io.bus_addr, io.bus_strobe}),
                  576'({1'b1, 32'h154, 4'hF}));
         if (io.mem_rsp_valid) break;
         cyc();
         t++;
      end
      io.bus_request_stall = 1'b0;
      check("stall_latency", 576'(t), 576'(20));
      cyc();

      // Error on beat 2 with a same-cycle clear.
      start(1'b0, 26'h6, 64'h0, 32'h0, 56'h66);
      t = 1;
      while (t < 40) begin
         io.bus_error = (t == 3);
         err_clear    = (t == 3);
         if (t == 3) check("err_before", 576'(err_sticky), 576'(0));
         if (t == 4) check("err_set_wins", 576'(err_sticky), 576'(1));
         if (io.mem_rsp_valid) break;
         cyc();
         t++;
      end
      io.bus_error = 1'b0;
      err_clear    = 1'b0;
      check("err_latency", 576'(t), 576'(17));
      check("err_held", 576'(err_sticky), 576'(1));
      cyc();
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      check("err_cleared", 576'(err_sticky), 576'(0));

      // Response back-pressure for four cycles.
      io.mem_rsp_ready = 1'b0;
      start(1'b0, 26'h7, 64'h0, 32'h0, 56'hAB_CDEF);
      t = 1;
      while (t < 40 && !io.mem_rsp_valid) begin
         cyc();
         t++;
      end
      check("bp_latency", 576'(t), 576'(17));
      for (int k = 0; k < 4; k++) begin
         check("rsp_hold", 576'({io.mem_rsp_valid, io.mem_req_ready, io.mem_rsp_tag, io.mem_rsp_data}),
               576'({1'b1, 1'b0, 56'hAB_CDEF, exp_line()}));
         cyc();
      end
      io.mem_rsp_ready = 1'b1;
      cyc();
      check("bp_drained", 576'({exp_rsp.size(), io.mem_req_ready}), 576'({32'd0, 1'b1}));

      // Reset pulse during read beat 7.
      start(1'b0, 26'h8, 64'h0, 32'h0, 56'h88);
      for (int k = 1; k < 8; k++) cyc();
      check("pre_reset_beat7", 576'({io.bus_ren, io.bus_addr}), 576'({1'b1, 32'h21C}));
      nRST = 1'b0;
      #1;
      check("reset_drop", 576'({io.bus_ren, io.bus_wen, busy, io.mem_req_ready, io.mem_rsp_valid}),
            576'(5'b00010));
      exp_beats.delete();
      exp_rsp.delete();
      @(posedge clk);
      #1 nRST = 1'b1;
      rsp_seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (io.mem_rsp_valid || io.bus_ren) rsp_seen++;
         cyc();
      end
      check("no_rsp_after_reset", 576'(rsp_seen), 576'(0));
      check("idle_after_reset", 576'({io.mem_req_ready, busy}), 576'(2'b10));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
